ifft_cp_inserter: RTL and testbench

- Consumer for the IFFT output stream (ifft_oaddr/ifft_ore/ifft_oim/ifft_oen).
- Captures each 2^NFFT_LOG2-point symbol into a ping-pong sample buffer, in whatever address order the IFFT delivers it.
- Replays each captured symbol in natural time order as a continuous sample stream, with a cyclic prefix prepended.
- Sits between the IFFT and the transmit DAC/serialiser path.

---
 rtl/ifft_cp_inserter.sv | 163 ++++++++++++++++
 tb/tb_ifft_cp_inserter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_cp_inserter.sv
// ifft_cp_inserter: captures IFFT output symbols (any address order) into a two-bank
// ping-pong buffer and replays each one in natural time order with a cyclic prefix.
module ifft_cp_inserter #(
    parameter int unsigned DW        = 16,
    parameter int unsigned NFFT_LOG2 = 7,
    parameter int unsigned CP_LEN    = 32
) (
    input  logic                 iclk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        ifft_ore,
    input  logic [DW-1:0]        ifft_oim,
    input  logic [NFFT_LOG2-1:0] ifft_oaddr,
    input  logic                 ifft_oen,
    output logic [DW-1:0]        tx_re,
    output logic [DW-1:0]        tx_im,
    output logic                 tx_en,
    output logic                 tx_sym_start,
    output logic                 tx_cp,
    output logic                 overflow
);

    localparam int unsigned          N        = 2 ** NFFT_LOG2;
    localparam logic [NFFT_LOG2-1:0] LastAddr = NFFT_LOG2'(N - 1);
    // Wraps to 0 when CP_LEN is 0, which is also the first body address.
    localparam logic [NFFT_LOG2-1:0] CpStart  = NFFT_LOG2'(N - CP_LEN);
    localparam bit                   HasCp    = (CP_LEN != 0);

    typedef enum logic [1:0] {
        StIdle,
        StCp,
        StBody
    } state_e;

    // Bank select is the address MSB: {bank, sample index}.
    logic [2*DW-1:0]      mem_q [2*N];

    logic [1:0]           full_q, full_d;
    logic                 wb_q;
    logic                 rb_q;
    logic [NFFT_LOG2-1:0] wcnt_q;
    logic                 wr_ok;
    logic                 wr_last;

    state_e               state_q, state_d;
    logic [NFFT_LOG2-1:0] rcnt_q, rcnt_d;
    logic                 iss_vld;
    logic                 iss_cp;
    logic                 iss_start;
    logic [NFFT_LOG2-1:0] iss_addr;
    logic                 rd_last;

    assign wr_ok    = ifft_oen && !full_q[wb_q];
    assign wr_last  = wr_ok && (wcnt_q == LastAddr);
    assign overflow = ifft_oen && full_q[wb_q];

    // Sample storage write port; contents are not reset.
    always_ff @(posedge iclk) begin
        if (wr_ok) begin
            mem_q[{wb_q, ifft_oaddr}] <= {ifft_ore, ifft_oim};
        end
    end

    // Write count and write bank; the count wraps to 0 on the last sample of a symbol.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wb_q   <= 1'b0;
        end else if (wr_ok) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wr_last) begin
                wb_q <= ~wb_q;
            end
        end
    end

    // Bank-full flags: set by the writer and cleared by the reader independently.
    always_comb begin
        full_d = full_q;
        if (wr_last) begin
            full_d[wb_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rb_q] = 1'b0;
        end
    end

    // Read address issued this cycle; Idle issues the first sample itself to save a cycle.
    always_comb begin
        iss_vld   = 1'b0;
        iss_cp    = 1'b0;
        iss_start = 1'b0;
        iss_addr  = rcnt_q;
        case (state_q)
            StIdle: begin
                if (full_q[rb_q]) begin
                    iss_vld   = 1'b1;
                    iss_start = 1'b1;
                    iss_cp    = HasCp;
                    iss_addr  = CpStart;
                end
            end
            StCp: begin
                iss_vld = 1'b1;
                iss_cp  = 1'b1;
            end
            StBody: begin
                iss_vld = 1'b1;
            end
            default: ;
        endcase
    end

    // Next read state. The body exit always returns to Idle: Idle then restarts in the
    // very next cycle if the other bank is (or has just become) full, so there is no gap.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rd_last = 1'b0;
        if (iss_vld) begin
            rcnt_d = iss_addr + 1'b1;
            if (iss_addr == LastAddr) begin
                if (iss_cp) begin
                    state_d = StBody;
                end else begin
                    state_d = StIdle;
                    rd_last = 1'b1;
                end
            end else begin
                state_d = iss_cp ? StCp : StBody;
            end
        end
    end

    // Read FSM, full flags, read bank and registered output stage.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rcnt_q       <= '0;
            full_q       <= '0;
            rb_q         <= 1'b0;
            tx_en        <= 1'b0;
            tx_cp        <= 1'b0;
            tx_sym_start <= 1'b0;
            tx_re        <= '0;
            tx_im        <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            full_q       <= full_d;
            tx_en        <= iss_vld;
            tx_cp        <= iss_cp;
            tx_sym_start <= iss_start;
            if (rd_last) begin
                rb_q <= ~rb_q;
            end
            // Data holds its last value while no read is issued.
            if (iss_vld) begin
                {tx_re, tx_im} <= mem_q[{rb_q, iss_addr}];
            end
        end
    end

endmodule

// File: tb/tb_ifft_cp_inserter.sv
// Bench for ifft_cp_inserter: directed scenarios with random data and address orders,
// checked against a symbol-level model of the expected transmit stream.
module tb_ifft_cp_inserter;

    localparam int DW = 16;
    localparam int NL = 7;
    localparam int N  = 1 << NL;
    localparam int CP = 32;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          cp;
        logic          st;
        int            cyc;
    } smp_t;

    logic          iclk  = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] ifft_ore   = '0;
    logic [DW-1:0] ifft_oim   = '0;
    logic [NL-1:0] ifft_oaddr = '0;
    logic          oen_a = 1'b0;
    logic          oen_b = 1'b0;

    logic [DW-1:0] tx_re_a, tx_im_a, tx_re_b, tx_im_b;
    logic          tx_en_a, tx_sym_start_a, tx_cp_a, overflow_a;
    logic          tx_en_b, tx_sym_start_b, tx_cp_b, overflow_b;

    ifft_cp_inserter #(.DW(DW), .NFFT_LOG2(NL), .CP_LEN(CP)) dut_a (
        .iclk         (iclk),
        .rst_n        (rst_n),
        .ifft_ore     (ifft_ore),
        .ifft_oim     (ifft_oim),
        .ifft_oaddr   (ifft_oaddr),
        .ifft_oen     (oen_a),
        .tx_re        (tx_re_a),
        .tx_im        (tx_im_a),
        .tx_en        (tx_en_a),
        .tx_sym_start (tx_sym_start_a),
        .tx_cp        (tx_cp_a),
        .overflow     (overflow_a)
    );

    ifft_cp_inserter #(.DW(DW), .NFFT_LOG2(NL), .CP_LEN(0)) dut_b (
        .iclk         (iclk),
        .rst_n        (rst_n),
        .ifft_ore     (ifft_ore),
        .ifft_oim     (ifft_oim),
        .ifft_oaddr   (ifft_oaddr),
        .ifft_oen     (oen_b),
        .tx_re        (tx_re_b),
        .tx_im        (tx_im_b),
        .tx_en        (tx_en_b),
        .tx_sym_start (tx_sym_start_b),
        .tx_cp        (tx_cp_b),
        .overflow     (overflow_b)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    // Output monitor
    smp_t got_a[$];
    smp_t got_b[$];
    int   ovf_a = 0;
    int   ovf_b = 0;
    always @(negedge iclk) begin
        if (tx_en_a) got_a.push_back('{tx_re_a, tx_im_a, tx_cp_a, tx_sym_start_a, cyc});
        if (tx_en_b) got_b.push_back('{tx_re_b, tx_im_b, tx_cp_b, tx_sym_start_b, cyc});
        if (overflow_a) ovf_a++;
        if (overflow_b) ovf_b++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-DUT ping-pong contents and the expected output stream.
    logic [DW-1:0] mre [2][2][N];
    logic [DW-1:0] mim [2][2][N];
    int            wb_m [2] = '{0, 0};
    int            wc_m [2] = '{0, 0};
    smp_t          exp_a[$];
    smp_t          exp_b[$];
    int            cidx [2] = '{0, 0};
    int            last_oen = 0;

    task automatic mdl_wr(input int d, input int a, input logic [DW-1:0] re,
                          input logic [DW-1:0] im);
        int   cpl;
        int   ad;
        smp_t e;
        cpl = (d == 0) ? CP : 0;
        mre[d][wb_m[d]][a] = re;
        mim[d][wb_m[d]][a] = im;
        wc_m[d]++;
        if (wc_m[d] == N) begin
            for (int i = 0; i < cpl + N; i++) begin
                ad    = (i < cpl) ? (N - cpl + i) : (i - cpl);
                e.re  = mre[d][wb_m[d]][ad];
                e.im  = mim[d][wb_m[d]][ad];
                e.cp  = (i < cpl);
                e.st  = (i == 0);
                e.cyc = 0;
                if (d == 0) exp_a.push_back(e);
                else exp_b.push_back(e);
            end
            wc_m[d] = 0;
            wb_m[d] ^= 1;
        end
    endtask

    // Stimulus symbol: ord[i] is the address of the i-th write.
    int            ord [N];
    logic [DW-1:0] dre [N];
    logic [DW-1:0] dim [N];

    function automatic int brev(input int x);
        int r = 0;
        for (int b = 0; b < NL; b++) r |= ((x >> b) & 1) << (NL - 1 - b);
        return r;
    endfunction

    // mode 0: in order, re=addr im=-addr; 1: bit-reversed same data; 2: random perm/data
    task automatic make_sym(input int mode);
        int j;
        int t;
        for (int i = 0; i < N; i++) ord[i] = (mode == 1) ? brev(i) : i;
        if (mode == 2) begin
            for (int i = N - 1; i > 0; i--) begin
                j      = $urandom_range(0, i);
                t      = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
        end
        for (int i = 0; i < N; i++) begin
            dre[i] = (mode == 2) ? DW'($urandom) : DW'(ord[i]);
            dim[i] = (mode == 2) ? DW'($urandom) : DW'(-ord[i]);
        end
    endtask

    // Drives n writes; the first ndrop are expected to be dropped. Leaves oen asserted.
    task automatic send(input int d, input bit gaps, input int ndrop, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge iclk); #1;
                oen_a = 1'b0;
                oen_b = 1'b0;
            end
            @(posedge iclk); #1;
            ifft_oaddr = NL'(ord[i]);
            ifft_ore   = dre[i];
            ifft_oim   = dim[i];
            oen_a      = (d == 0);
            oen_b      = (d == 1);
            last_oen   = cyc;
            if (i >= ndrop) mdl_wr(d, ord[i], dre[i], dim[i]);
        end
    endtask

    task automatic idle();
        @(posedge iclk); #1;
        oen_a = 1'b0;
        oen_b = 1'b0;
    endtask

    function automatic int gsz(input int d);
        return (d == 0) ? got_a.size() : got_b.size();
    endfunction

    task automatic drain(input int d, input int target);
        int n = 0;
        while (gsz(d) < target && n < 2000) begin
            @(negedge iclk); #1;
            n++;
        end
        chk($sformatf("d%0d drain to %0d", d, target), 64'(gsz(d) >= target), 64'd1);
    endtask

    // Compare every not-yet-checked expected sample, plus cycle contiguity within symbols.
    task automatic cmp(input int d);
        smp_t g;
        smp_t gp;
        smp_t e;
        int   esz;
        esz = (d == 0) ? exp_a.size() : exp_b.size();
        for (int k = cidx[d]; k < esz && k < gsz(d); k++) begin
            if (d == 0) begin
                g = got_a[k];
                e = exp_a[k];
            end else begin
                g = got_b[k];
                e = exp_b[k];
            end
            chk($sformatf("d%0d sample %0d {re,im,cp,st}", d, k),
                64'({g.re, g.im, g.cp, g.st}), 64'({e.re, e.im, e.cp, e.st}));
            if (!e.st && k > 0) begin
                gp = (d == 0) ? got_a[k-1] : got_b[k-1];
                chk($sformatf("d%0d sample %0d contiguous", d, k), 64'(g.cyc - gp.cyc), 64'd1);
            end
        end
        cidx[d] = esz;
    endtask

    initial begin
        int s;
        int o0;

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge iclk);
        @(negedge iclk); #1;
        chk("rst tx_en", 64'(tx_en_a), 64'd0);
        chk("rst tx_re/tx_im", 64'({tx_re_a, tx_im_a}), 64'd0);
        chk("rst tx_cp/tx_sym_start", 64'({tx_cp_a, tx_sym_start_a}), 64'd0);
        chk("rst overflow", 64'(overflow_a), 64'd0);
        chk("rst b tx_en", 64'(tx_en_b), 64'd0);
        rst_n = 1'b1;

        // In-order symbol, re=addr, im=-addr
        make_sym(0);
        s = got_a.size();
        send(0, 1'b0, 0, N);
        idle();
        drain(0, s + N + CP);
        cmp(0);
        chk("inorder latency", 64'(got_a[s].cyc - last_oen), 64'd2);
        chk("inorder first re", 64'(got_a[s].re), 64'(DW'(N - CP)));
        repeat (3) @(negedge iclk); #1;
        chk("inorder tx_en low after symbol", 64'(tx_en_a), 64'd0);
        chk("inorder hold", 64'({tx_re_a, tx_im_a}), 64'({DW'(N - 1), DW'(-(N - 1))}));

        // Bit-reversed order with gaps: same output
        make_sym(1);
        s = got_a.size();
        send(0, 1'b1, 0, N);
        idle();
        drain(0, s + N + CP);
        cmp(0);
        chk("bitrev latency", 64'(got_a[s].cyc - last_oen), 64'd2);

        // Random data with a duplicated address (the missing address keeps stale bank data)
        make_sym(2);
        ord[7] = ord[3];
        s = got_a.size();
        send(0, 1'b1, 0, N);
        idle();
        drain(0, s + N + CP);
        cmp(0);

        // Two symbols back-to-back
        o0 = ovf_a;
        s  = got_a.size();
        make_sym(2);
        send(0, 1'b0, 0, N);
        make_sym(2);
        send(0, 1'b0, 0, N);
        idle();
        drain(0, s + 2 * (N + CP));
        cmp(0);
        chk("b2b span", 64'(got_a[s + 2*(N+CP) - 1].cyc - got_a[s].cyc), 64'(2*(N+CP) - 1));
        chk("b2b no overflow", 64'(ovf_a - o0), 64'd0);

        // Three symbols continuously: symbol 1 is read for CP+N cycles starting one cycle
        // after its last write, while symbol 3 arrives N cycles after that last write, so
        // the first CP writes of symbol 3 find both banks full.
        o0 = ovf_a;
        s  = got_a.size();
        make_sym(2);
        send(0, 1'b0, 0, N);
        make_sym(2);
        send(0, 1'b0, 0, N);
        make_sym(0);
        for (int i = 0; i < N; i++) dre[i] = DW'($urandom);
        send(0, 1'b0, CP, N);
        idle();
        chk("overflow pulses", 64'(ovf_a - o0), 64'(CP));
        for (int i = 0; i < CP; i++) begin
            dre[i] = DW'($urandom);
            dim[i] = DW'($urandom);
        end
        send(0, 1'b0, 0, CP);
        idle();
        drain(0, s + 3 * (N + CP));
        cmp(0);
        chk("overflow count settled", 64'(ovf_a - o0), 64'(CP));

        // Reset at output sample 50
        make_sym(2);
        s = got_a.size();
        send(0, 1'b0, 0, N);
        idle();
        drain(0, s + 50);
        rst_n = 1'b0;
        #1;
        chk("midrst tx_en", 64'(tx_en_a), 64'd0);
        chk("midrst tx_re/tx_im", 64'({tx_re_a, tx_im_a}), 64'd0);
        chk("midrst tx_cp/tx_sym_start", 64'({tx_cp_a, tx_sym_start_a}), 64'd0);
        chk("midrst overflow", 64'(overflow_a), 64'd0);
        while (exp_a.size() > got_a.size()) void'(exp_a.pop_back());
        cmp(0);
        wb_m = '{0, 0};
        wc_m = '{0, 0};
        repeat (3) @(posedge iclk);
        #1 rst_n = 1'b1;
        s = got_a.size();
        repeat (300) @(negedge iclk);
        #1;
        chk("no output after reset", 64'(got_a.size()), 64'(s));
        make_sym(2);
        send(0, 1'b1, 0, N);
        idle();
        drain(0, s + N + CP);
        cmp(0);
        chk("post-reset latency", 64'(got_a[s].cyc - last_oen), 64'd2);

        // CP_LEN = 0 instance
        s = got_a.size();
        make_sym(2);
        send(1, 1'b1, 0, N);
        idle();
        drain(1, N);
        cmp(1);
        chk("cp0 latency", 64'(got_b[0].cyc - last_oen), 64'd2);
        chk("cp0 other instance idle", 64'(got_a.size()), 64'(s));
        chk("cp0 no overflow", 64'(ovf_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
